// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared req/ack memory port and steers the shared-ALU datapath; traps on bad opcodes and bus timeouts.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  alu_zero,
    input  logic                  alu_lt,
    input  logic                  alu_ltu,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  trap,
    output logic                  bus_error
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_bus_error;
    logic             w_known_op;
    logic             w_f7_alt;
    logic             w_taken;
    logic             w_branch_ok;
    logic             w_mem_wait;
    logic             w_timeout;
    logic [3:0]       w_alu_op;

    function automatic logic [3:0] aluDecode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_known_op = 1'b1;
            default:                           w_known_op = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  w_taken = alu_zero;
            3'b001:  w_taken = !alu_zero;
            3'b100:  w_taken = alu_lt;
            3'b101:  w_taken = !alu_lt;
            3'b110:  w_taken = alu_ltu;
            3'b111:  w_taken = !alu_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_f7_alt    = |(funct7 & 7'b0100000);
    assign w_branch_ok = (funct3[2:1] != 2'b01);
    assign w_mem_wait  = (r_state == S_FETCH) || (r_state == S_MEM);
    // An ack arriving in the final allowed cycle takes priority over the timeout.
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_wait && !mem_ack
                         && (r_wait_cnt == CNT_W'(MEM_TIMEOUT));

    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        result_src   = 2'b00;
        w_alu_op     = ALU_ADD;
        trap         = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                    if (mem_ack) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        w_next_state = S_DECODE;
                    end else if (w_timeout) begin
                        w_next_state = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_a    = 2'b01;
                    alu_src_b    = 2'b01;
                    w_next_state = w_known_op ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_R: begin
                            w_alu_op     = aluDecode(funct3, w_f7_alt);
                            w_next_state = S_WB;
                        end
                        OP_I: begin
                            alu_src_b    = 2'b01;
                            w_alu_op     = aluDecode(funct3, (funct3 == 3'b101) && w_f7_alt);
                            w_next_state = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_b    = 2'b01;
                            w_next_state = S_MEM;
                        end
                        OP_BRANCH: begin
                            w_alu_op     = ALU_SUB;
                            pc_src       = 1'b1;
                            pc_write     = w_branch_ok && w_taken;
                            w_next_state = w_branch_ok ? S_FETCH : S_TRAP;
                        end
                        OP_JAL: begin
                            pc_write     = 1'b1;
                            pc_src       = 1'b1;
                            w_next_state = S_WB;
                        end
                        OP_JALR: begin
                            alu_src_b    = 2'b01;
                            pc_write     = 1'b1;
                            w_next_state = S_WB;
                        end
                        OP_AUIPC: begin
                            alu_src_a    = 2'b01;
                            alu_src_b    = 2'b01;
                            w_next_state = S_WB;
                        end
                        OP_LUI:  w_next_state = S_WB;
                        default: w_next_state = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    mem_we  = (opcode == OP_STORE);
                    if (mem_ack) begin
                        w_next_state = (opcode == OP_STORE) ? S_FETCH : S_WB;
                    end else if (w_timeout) begin
                        w_next_state = S_TRAP;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    case (opcode)
                        OP_LOAD:         result_src = 2'b01;
                        OP_JAL, OP_JALR: result_src = 2'b10;
                        OP_LUI:          result_src = 2'b11;
                        default:         result_src = 2'b00;
                    endcase
                    w_next_state = S_FETCH;
                end
                S_TRAP:  trap = 1'b1;
                default: w_next_state = S_TRAP;
            endcase
        end
    end

    assign alu_control = ALU_CTRL_W'(w_alu_op);
    assign bus_error   = r_bus_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_wait_cnt  <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
            if (w_next_state != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_mem_wait && !mem_ack && (r_wait_cnt != '1)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus pushes hand-computed per-cycle
// control words into a queue, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_multicycle_control_unit;
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result_src;
        logic [3:0] alu_ctrl;
        logic       trap;
        logic       bus_error;
    } ctrl_t;

    typedef struct {
        string name;
        ctrl_t exp;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_zero, alu_lt, alu_ltu, mem_ack;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_control;
    logic       trap, bus_error;

    item_t      sbQueue[$];
    int         errors = 0;
    int         checks = 0;
    logic [6:0] nxtOp;
    logic [2:0] nxtF3;
    logic [6:0] nxtF7;
    ctrl_t      FW, FA, DEC, ZERO, MEMLD, MEMST, TRAPI, TRAPB;
    item_t      monItem;
    ctrl_t      monAct;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_control(alu_control), .trap(trap), .bus_error(bus_error)
    );

    function automatic ctrl_t ex(input logic req, we, adr, irw, pcw, pcs, rw,
                                 input logic [1:0] sa, sb, rs, input logic [3:0] alu,
                                 input logic tr, be);
        ctrl_t c;
        c = {req, we, adr, irw, pcw, pcs, rw, sa, sb, rs, alu, tr, be};
        return c;
    endfunction

    task automatic checkOutput(input item_t it);
        monAct = {mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write,
                  alu_src_a, alu_src_b, result_src, alu_control, trap, bus_error};
        checks++;
        if (monAct !== it.exp) begin
            errors++;
            $display("[TB] FAIL %s: got %05h expected %05h", it.name, monAct, it.exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sbQueue.size() > 0) begin
                monItem = sbQueue.pop_front();
                checkOutput(monItem);
            end
        end
    end

    task automatic applyStimulus(input string name, input logic rst, input logic ack,
                                 input logic [2:0] flg, input ctrl_t exp);
        item_t it;
        @(posedge clk);
        #1;
        rst_n   = rst;
        mem_ack = ack;
        {alu_zero, alu_lt, alu_ltu} = flg;
        opcode  = nxtOp;
        funct3  = nxtF3;
        funct7  = nxtF7;
        it.name = name;
        it.exp  = exp;
        sbQueue.push_back(it);
    endtask

    task automatic fetchDecode(input string name, input logic [6:0] op,
                               input logic [2:0] f3, input logic [6:0] f7);
        nxtOp = op;
        nxtF3 = f3;
        nxtF7 = f7;
        applyStimulus({name, "_fetch"}, 1'b1, 1'b1, 3'b000, FA);
        applyStimulus({name, "_decode"}, 1'b1, 1'b0, 3'b000, DEC);
    endtask

    function automatic ctrl_t wbExp(input logic [1:0] rs);
        return ex(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, rs, 4'd0, 0, 0);
    endfunction

    initial begin
        logic [2:0] rTab  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
        logic [6:0] rF7   [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
        logic [3:0] rAlu  [10] = '{4'd0, 4'd1, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd8, 4'd3, 4'd2};
        logic [2:0] iTab  [9]  = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd5, 3'd5, 3'd1, 3'd7, 3'd6};
        logic [6:0] iF7   [9]  = '{7'h7F, 7'h20, 7'h7F, 7'h00, 7'h20, 7'h00, 7'h00, 7'h7F, 7'h20};
        logic [3:0] iAlu  [9]  = '{4'd0, 4'd0, 4'd5, 4'd9, 4'd8, 4'd7, 4'd6, 4'd2, 4'd3};
        logic [2:0] bF3   [12] = '{3'd6, 3'd6, 3'd0, 3'd0, 3'd1, 3'd1, 3'd4, 3'd4, 3'd5, 3'd5, 3'd7, 3'd7};
        logic [2:0] bFlg  [12] = '{3'b001, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000,
                                   3'b010, 3'b101, 3'b010, 3'b000, 3'b001, 3'b110};
        logic       bTaken[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        nxtOp = 7'd0; nxtF3 = 3'd0; nxtF7 = 7'd0;

        FW    = ex(1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'd0, 0, 0);
        FA    = ex(1, 0, 0, 1, 1, 0, 0, 2'b10, 2'b10, 2'b00, 4'd0, 0, 0);
        DEC   = ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'd0, 0, 0);
        ZERO  = ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
        MEMLD = ex(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
        MEMST = ex(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
        TRAPI = ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 1, 0);
        TRAPB = ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 1, 1);

        applyStimulus("reset0", 1'b0, 1'b0, 3'b000, ZERO);
        applyStimulus("reset_ack", 1'b0, 1'b1, 3'b111, ZERO);

        for (int i = 0; i < 10; i++) begin
            fetchDecode($sformatf("R%0d", i), 7'b0110011, rTab[i], rF7[i]);
            applyStimulus($sformatf("R%0d_exec", i), 1'b1, 1'b0, 3'b000,
                          ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, rAlu[i], 0, 0));
            applyStimulus($sformatf("R%0d_wb", i), 1'b1, 1'b0, 3'b000, wbExp(2'b00));
        end

        for (int i = 0; i < 9; i++) begin
            fetchDecode($sformatf("I%0d", i), 7'b0010011, iTab[i], iF7[i]);
            applyStimulus($sformatf("I%0d_exec", i), 1'b1, 1'b0, 3'b000,
                          ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, iAlu[i], 0, 0));
            applyStimulus($sformatf("I%0d_wb", i), 1'b1, 1'b0, 3'b000, wbExp(2'b00));
        end

        for (int i = 0; i < 12; i++) begin
            fetchDecode($sformatf("B%0d", i), 7'b1100011, bF3[i], 7'h00);
            applyStimulus($sformatf("B%0d_exec", i), 1'b1, 1'b0, bFlg[i],
                          ex(0, 0, 0, 0, bTaken[i], 1, 0, 2'b00, 2'b00, 2'b00, 4'd1, 0, 0));
        end

        fetchDecode("lw", 7'b0000011, 3'd2, 7'h00);
        applyStimulus("lw_exec", 1'b1, 1'b0, 3'b000,
                      ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'd0, 0, 0));
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("lw_memwait%0d", i), 1'b1, 1'b0, 3'b000, MEMLD);
        applyStimulus("lw_memack", 1'b1, 1'b1, 3'b000, MEMLD);
        applyStimulus("lw_wb", 1'b1, 1'b0, 3'b000, wbExp(2'b01));

        fetchDecode("sw", 7'b0100011, 3'd2, 7'h00);
        applyStimulus("sw_exec", 1'b1, 1'b0, 3'b000,
                      ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'd0, 0, 0));
        applyStimulus("sw_memack", 1'b1, 1'b1, 3'b000, MEMST);
        applyStimulus("sw_fetch_after", 1'b1, 1'b0, 3'b000, FW);

        fetchDecode("jal", 7'b1101111, 3'd0, 7'h00);
        applyStimulus("jal_exec", 1'b1, 1'b0, 3'b000,
                      ex(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0));
        applyStimulus("jal_wb", 1'b1, 1'b0, 3'b000, wbExp(2'b10));

        fetchDecode("jalr", 7'b1100111, 3'd0, 7'h00);
        applyStimulus("jalr_exec", 1'b1, 1'b0, 3'b000,
                      ex(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 4'd0, 0, 0));
        applyStimulus("jalr_wb", 1'b1, 1'b0, 3'b000, wbExp(2'b10));

        fetchDecode("lui", 7'b0110111, 3'd0, 7'h00);
        applyStimulus("lui_exec", 1'b1, 1'b0, 3'b000, ZERO);
        applyStimulus("lui_wb", 1'b1, 1'b0, 3'b000, wbExp(2'b11));

        fetchDecode("auipc", 7'b0010111, 3'd0, 7'h00);
        applyStimulus("auipc_exec", 1'b1, 1'b0, 3'b000,
                      ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'd0, 0, 0));
        applyStimulus("auipc_wb", 1'b1, 1'b0, 3'b000, wbExp(2'b00));

        // Fifteen waits then an ack on the last allowed cycle: the ack must win.
        for (int i = 0; i < 15; i++) applyStimulus($sformatf("late_wait%0d", i), 1'b1, 1'b0, 3'b000, FW);
        fetchDecode("late", 7'b0110011, 3'd0, 7'h00);
        applyStimulus("late_exec", 1'b1, 1'b0, 3'b000, ZERO);
        applyStimulus("late_wb", 1'b1, 1'b0, 3'b000, wbExp(2'b00));

        for (int i = 0; i < 16; i++) applyStimulus($sformatf("to_wait%0d", i), 1'b1, 1'b0, 3'b000, FW);
        for (int i = 0; i < 3; i++) applyStimulus($sformatf("to_trap%0d", i), 1'b1, 1'b1, 3'b000, TRAPB);
        applyStimulus("to_reset", 1'b0, 1'b0, 3'b000, ZERO);
        applyStimulus("to_release", 1'b1, 1'b0, 3'b000, FW);

        fetchDecode("illegal", 7'h7F, 3'd0, 7'h00);
        applyStimulus("illegal_trap0", 1'b1, 1'b1, 3'b000, TRAPI);
        applyStimulus("illegal_trap1", 1'b1, 1'b0, 3'b000, TRAPI);
        applyStimulus("illegal_reset", 1'b0, 1'b0, 3'b000, ZERO);

        fetchDecode("midmem", 7'b0000011, 3'd2, 7'h00);
        applyStimulus("midmem_exec", 1'b1, 1'b0, 3'b000,
                      ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'd0, 0, 0));
        applyStimulus("midmem_wait", 1'b1, 1'b0, 3'b000, MEMLD);
        applyStimulus("midmem_reset", 1'b0, 1'b1, 3'b000, ZERO);
        applyStimulus("midmem_release", 1'b1, 1'b0, 3'b000, FW);
        applyStimulus("midmem_fetch", 1'b1, 1'b1, 3'b000, FA);

        for (int i = 0; i < 10 && sbQueue.size() != 0; i++) @(posedge clk);
        if (sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sbQueue.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
